// File: rtl/io_wait_engine.sv
// Status-poll offload: up to NUM_CH wait channels that watch a synchronised IO status
// bus with mask/compare, debounce and prescaled timeout, driving IO control bits while waiting.
module io_wait_engine #(
   parameter int NUM_CH      = 4,
   parameter int STAT_WIDTH  = 8,
   parameter int CTRL_WIDTH  = 8,
   parameter int CNT_WIDTH   = 12,
   parameter int PRESCALE    = 1,
   parameter int SYNC_STAGES = 2,
   parameter int MATCH_HOLD  = 1,
   localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [STAT_WIDTH-1:0]   STATUS,
   input  logic [SEL_W-1:0]        CH_SEL,
   input  logic                    START,
   input  logic                    ABORT,
   input  logic [1:0]              MODE,
   input  logic [STAT_WIDTH-1:0]   MASK,
   input  logic [STAT_WIDTH-1:0]   REF,
   input  logic [CNT_WIDTH-1:0]    LIMIT,
   input  logic [CTRL_WIDTH-1:0]   CTRL,
   output logic [NUM_CH-1:0]       BUSY,
   output logic [NUM_CH-1:0]       DONE,
   output logic [2*NUM_CH-1:0]     RESULT,
   output logic [CNT_WIDTH-1:0]    ELAPSED,
   output logic [CTRL_WIDTH-1:0]   CTRL_OUT,
   output logic                    IRQ
);

   localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int HOLD_W = (MATCH_HOLD > 1) ? $clog2(MATCH_HOLD) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MATCH_HOLD - 1);
   localparam logic [1:0] RES_NONE    = 2'b00;
   localparam logic [1:0] RES_MATCH   = 2'b01;
   localparam logic [1:0] RES_TIMEOUT = 2'b10;
   localparam logic [1:0] RES_ABORT   = 2'b11;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   function automatic logic match_fn(input logic [1:0] mode, input logic [STAT_WIDTH-1:0] stat,
                                     input logic [STAT_WIDTH-1:0] mask, input logic [STAT_WIDTH-1:0] refv);
      logic [STAT_WIDTH-1:0] m;
      m = stat & mask;
      case (mode)
         2'b00:   return m == (refv & mask);
         2'b01:   return m != (refv & mask);
         2'b10:   return |m;
         default: return m == mask;
      endcase
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   logic [STAT_WIDTH-1:0]        sync_q [SYNC_STAGES];
   logic [STAT_WIDTH-1:0]        s_stat;
   logic [PRE_W-1:0]             pre_q;
   logic                         tick;
   logic [NUM_CH-1:0]            busy_vec;
   logic [NUM_CH-1:0]            done_vec;
   logic [2*NUM_CH-1:0]          result_flat;
   logic [NUM_CH*CNT_WIDTH-1:0]  elapsed_flat;
   logic [NUM_CH*CTRL_WIDTH-1:0] ctrl_flat;
   logic                         irq_q;

   // status synchroniser stage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= STATUS;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s_stat = sync_q[SYNC_STAGES-1];

   // free-running prescaler; START does not realign it
   assign tick = (pre_q == PRE_LAST);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) pre_q <= '0;
      else     pre_q <= tick ? '0 : pre_q + PRE_W'(1);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t                 state_q, state_d;
      logic [1:0]             mode_q;
      logic [STAT_WIDTH-1:0]  mask_q, ref_q;
      logic [CNT_WIDTH-1:0]   limit_q;
      logic [CTRL_WIDTH-1:0]  ctrl_q;
      logic [CNT_WIDTH-1:0]   elapsed_q, elapsed_d;
      logic [HOLD_W-1:0]      hold_q, hold_d;
      logic [1:0]             result_q, result_d;
      logic                   done_q, done_d;
      logic                   sel, start_hit, abort_hit, match, complete, timeout, load;

      assign sel       = (CH_SEL == SEL_W'(g));
      assign start_hit = START & sel & ~ABORT;
      assign abort_hit = ABORT & sel;
      assign match     = match_fn(mode_q, s_stat, mask_q, ref_q);
      assign complete  = match && (hold_q == HOLD_LAST);
      assign timeout   = tick && (limit_q != '0) && ((elapsed_q + CNT_WIDTH'(1)) == limit_q);
      assign load      = (state_q == S_IDLE) && start_hit;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) state_q <= S_IDLE;
         else     state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            S_IDLE:  if (start_hit) state_d = S_WAIT;
            S_WAIT:  if (abort_hit || complete || timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // abort outranks completion, completion outranks timeout
      always_comb begin
         done_d    = 1'b0;
         result_d  = result_q;
         hold_d    = hold_q;
         elapsed_d = elapsed_q;
         case (state_q)
            S_IDLE: begin
               if (start_hit) begin
                  result_d  = RES_NONE;
                  hold_d    = '0;
                  elapsed_d = '0;
               end
            end
            S_WAIT: begin
               hold_d = match ? hold_q + HOLD_W'(1) : '0;
               if (tick) elapsed_d = sat_inc(elapsed_q);
               if (abort_hit) begin
                  result_d = RES_ABORT;
               end else if (complete) begin
                  result_d = RES_MATCH;
                  done_d   = 1'b1;
               end else if (timeout) begin
                  result_d = RES_TIMEOUT;
                  done_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            done_q    <= 1'b0;
            result_q  <= RES_NONE;
            hold_q    <= '0;
            elapsed_q <= '0;
         end else begin
            done_q    <= done_d;
            result_q  <= result_d;
            hold_q    <= hold_d;
            elapsed_q <= elapsed_d;
         end
      end

      always_ff @(posedge CLK) begin
         if (load) begin
            mode_q  <= MODE;
            mask_q  <= MASK;
            ref_q   <= REF;
            limit_q <= LIMIT;
            ctrl_q  <= CTRL;
         end
      end

      assign busy_vec[g]                             = (state_q == S_WAIT);
      assign done_vec[g]                             = done_q;
      assign result_flat[2*g +: 2]                   = result_q;
      assign elapsed_flat[g*CNT_WIDTH +: CNT_WIDTH]  = elapsed_q;
      assign ctrl_flat[g*CTRL_WIDTH +: CTRL_WIDTH]   = ctrl_q;
   end

   always_comb begin
      ELAPSED = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (CH_SEL == SEL_W'(i)) ELAPSED = elapsed_flat[i*CNT_WIDTH +: CNT_WIDTH];
   end

   always_comb begin
      CTRL_OUT = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (busy_vec[i]) CTRL_OUT = CTRL_OUT | ctrl_flat[i*CTRL_WIDTH +: CTRL_WIDTH];
   end

   // interrupt stage, one cycle behind DONE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) irq_q <= 1'b0;
      else     irq_q <= |done_vec;
   end

   assign BUSY   = busy_vec;
   assign DONE   = done_vec;
   assign RESULT = result_flat;
   assign IRQ    = irq_q;

endmodule
